// File: rtl/rom_image_loader.sv
// rom_image_loader: writer side of the cartridge image RAM. It takes a byte stream
// over a valid/ready handshake and writes it sequentially from address 0 through
// a synchronous write port, then reports done or error. It runs at boot, before
// the bus read path is enabled.
//
// Optional feature: ROM_IMAGE_LOADER_CHECKSUM_EN. When defined, one trailer byte is
// accepted after the data and is not written. The load ends in DONE only if
// (sum of data bytes + trailer) mod 256 == 0; otherwise it ends in ERROR.
//
// Ports:
//   clock        single clock, posedge
//   reset        asynchronous, active-high
//   start        1-cycle load request; sampled only in IDLE/DONE/ERROR
//   length       bytes to load (0..SIZE), sampled with start
//   in_data      stream byte
//   in_valid     stream byte valid
//   in_ready     loader accepts a byte this cycle
//   mem_address  RAM write address
//   mem_data     RAM write data
//   mem_we       RAM write strobe, one cycle per byte
//   busy         load in progress
//   done         image loaded OK, held until next start
//   error        load failed, held until next start
module rom_image_loader #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] SIZE = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  accept;
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  // Next-state, counter, write-port and status logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    // in_ready is registered and mirrors the state, so the handshake uses it directly.
    accept     = in_valid & in_ready_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          count_d = '0;
          len_d   = length;
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
          sum_d   = 8'(0);
`endif
          if (length > SIZE) begin
            state_d = S_ERROR;
          end else if (length == '0) begin
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = count_q[ADDR_WIDTH-1:0];
          mem_data_d = in_data;
          count_d    = count_q + CNT_W'(1);
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
          sum_d      = sum_q + 8'(in_data);
`endif
          // The final write lands in the cycle the next state becomes visible.
          if (count_d == len_q) begin
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
      S_CHECK: begin
        // The trailer byte is consumed but never written to RAM.
        if (accept) begin
          state_d = (8'(sum_q + 8'(in_data)) == 8'(0)) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d     = (state_d == S_LOAD) || (state_d == S_CHECK);
    in_ready_d = (state_d == S_CHECK) || ((state_d == S_LOAD) && (count_d < len_d));
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  // State and output registers; reset aborts a load immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      len_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
      sum_q      <= 8'(0);
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      len_q      <= len_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef ROM_IMAGE_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_address = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
